descriptor_dequeue: RTL and testbench
=====================================

# descriptor_dequeue

Reads queued descriptors out of the input-queue FIFO that the host/network descriptor multiplexer fills, and hands each one to a downstream consumer over the same wr/ack descriptor handshake the multiplexer accepts on its inputs. Descriptors are steered by packet type to a time-sensitive (TS) consumer or a best-effort (BE) consumer. The block sits on the read side of the input-queue FIFO in the network transmit path.

## Interface
- TIMEOUT_CYCLES, 1024: cycles to wait for ack before dropping a descriptor; used only with the timeout feature. Must be 2..65535.
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- iv_fifo_rdata  in  60  FIFO read data {pkt_type[59:57], tsntag[56:9], bufid[8:0]}; valid in the cycle after o_fifo_rd
- i_fifo_empty  in  1  FIFO empty flag
- o_fifo_rd  out  1  FIFO read strobe, one-cycle pulse
- ov_tsntag_ts / ov_bufid_ts / ov_pkt_type_ts  out  48/9/3  TS descriptor fields
- o_descriptor_wr_ts  out  1  TS descriptor valid; held until ack
- i_descriptor_ack_ts  in  1  TS consumer ack pulse
- ov_tsntag_be / ov_bufid_be / ov_pkt_type_be  out  48/9/3  BE descriptor fields
- o_descriptor_wr_be  out  1  BE descriptor valid; held until ack
- i_descriptor_ack_be  in  1  BE consumer ack pulse
- ov_drop_cnt  out  16  saturating count of timed-out descriptors

## Operation
- Routing: pkt_type 3'd0, 3'd1, 3'd2 go to TS. All other values go to BE.
- States:
  - IDLE_S: if i_fifo_empty==0, set o_fifo_rd=1 and go to READ_S. Otherwise stay.
  - READ_S: o_fifo_rd=0; go to CAPTURE_S.
  - CAPTURE_S: latch iv_fifo_rdata into the selected port's field registers, set that port's wr=1, go to WAIT_ACK_S.
  - WAIT_ACK_S: hold wr and fields stable. When the selected port's ack is sampled high, clear wr and that port's fields to 0 and go to IDLE_S.
  - default: go to IDLE_S with all outputs at 0.
- An ack on the non-selected port, or an ack in any state other than WAIT_ACK_S, is ignored.
- The fields of a port are 0 whenever its wr is 0.
- At most one of o_descriptor_wr_ts and o_descriptor_wr_be is high at any time.
- One descriptor is outstanding at a time. There is no reordering.
- Reset: all outputs 0, including ov_drop_cnt; state is IDLE_S. Reset mid-handshake drops the outstanding descriptor. A descriptor popped but not yet captured is lost; this is accepted.

## Timing
- i_fifo_empty sampled low at edge E0:
  - o_fifo_rd high during E0..E1
  - data latched at E2
  - wr high from E2
- An ack sampled at edge Ea deasserts wr at Ea.
- The next o_fifo_rd cannot assert before Ea+1 (one IDLE_S cycle).
- Peak throughput is one descriptor per 4 cycles with same-cycle ack.
- i_fifo_empty is only sampled in IDLE_S.

## Configuration
- Macro DESC_ACK_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to WAIT_ACK_S and increments each WAIT_ACK_S cycle.
  - If no ack has arrived when the counter reaches TIMEOUT_CYCLES-1, wr and fields clear at the next edge and state goes to IDLE_S.
  - ov_drop_cnt increments by 1, saturating at 16'hFFFF.
  - An ack in the same cycle as expiry wins: no drop is counted.
- Undefined: WAIT_ACK_S waits indefinitely; ov_drop_cnt is tied to 0 and no counter logic is built.

## Structure
- Shared package tsn_desc_pkg:
  - field widths: TSNTAG_W=48, BUFID_W=9, PKT_TYPE_W=3, DESC_W=60
  - bit-slice positions
  - TS pkt_type encodings
  - state localparams IDLE_S, READ_S, CAPTURE_S, WAIT_ACK_S
- One sub-module, desc_ack_timer (wait counter, expiry flag, drop counter), instantiated only under DESC_ACK_TIMEOUT_EN.

## Test plan
- Reset: assert i_rst mid-WAIT_ACK_S -> all outputs 0 at the asynchronous assertion; state IDLE_S after release; ov_drop_cnt=0.
- Single TS descriptor: FIFO holds {3'd1, 48'h0123_4567_89AB, 9'h05}.
  - o_fifo_rd pulses one cycle.
  - wr_ts rises 2 cycles later with tsntag=48'h0123_4567_89AB, bufid=9'h05.
  - Ack after 3 cycles -> wr_ts low next edge; fields zero.
- BE routing: pkt_type=3'd5, bufid=9'h1FF -> only wr_be asserts.
  - An ack_ts pulse during the wait is ignored.
  - ack_be completes the transfer.
- Back-to-back: 4 descriptors queued, consumer acks the cycle wr rises -> 4 transfers in 16 cycles, order preserved, wr_ts and wr_be never high together.
- Timeout with DESC_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> wr clears after 8 WAIT_ACK_S cycles, ov_drop_cnt=1, next descriptor popped.
  - Repeat with ack on the 8th cycle -> no drop counted.
- Empty FIFO: i_fifo_empty held 1 for 100 cycles -> o_fifo_rd never asserts; all outputs remain 0.

Source files
------------

// File: rtl/tsn_desc_pkg.sv
// Shared descriptor definitions for the input-queue dequeue path:
// field widths, bit positions, TS type codes and dequeue FSM states.
package tsn_desc_pkg;

    localparam int TSNTAG_W   = 48;
    localparam int BUFID_W    = 9;
    localparam int PKT_TYPE_W = 3;
    localparam int DESC_W     = 60;

    localparam int BUFID_LSB    = 0;
    localparam int BUFID_MSB    = 8;
    localparam int TSNTAG_LSB   = 9;
    localparam int TSNTAG_MSB   = 56;
    localparam int PKT_TYPE_LSB = 57;
    localparam int PKT_TYPE_MSB = 59;

    localparam logic [PKT_TYPE_W-1:0] PKT_TS0 = 3'd0;
    localparam logic [PKT_TYPE_W-1:0] PKT_TS1 = 3'd1;
    localparam logic [PKT_TYPE_W-1:0] PKT_TS2 = 3'd2;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        READ_S     = 2'd1,
        CAPTURE_S  = 2'd2,
        WAIT_ACK_S = 2'd3
    } state_e;

    typedef struct packed {
        logic [PKT_TYPE_W-1:0] pkt_type;
        logic [TSNTAG_W-1:0]   tsntag;
        logic [BUFID_W-1:0]    bufid;
    } desc_t;

    function automatic logic is_ts(input logic [PKT_TYPE_W-1:0] t);
        return (t == PKT_TS0) || (t == PKT_TS1) || (t == PKT_TS2);
    endfunction

endpackage

// File: rtl/desc_ack_timer.sv
// Ack wait counter, expiry flag and saturating drop counter.
// Built only when DESC_ACK_TIMEOUT_EN is defined.
module desc_ack_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_wait,
    input  logic        i_ack,
    output logic        o_expire,
    output logic [15:0] ov_drop_cnt
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign o_expire    = i_wait && (wait_cnt_q == LAST);
    assign ov_drop_cnt = drop_cnt_q;

    // Clear on entry to the wait, count each wait cycle; count drops
    // only when expiry is not rescued by a same-cycle ack.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (i_start) begin
            wait_cnt_d = '0;
        end else if (i_wait) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
        if (o_expire && !i_ack && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: rtl/descriptor_dequeue.sv
// Pops descriptors from the input-queue FIFO and steers each to the TS
// or BE consumer over a wr/ack handshake. Optional: DESC_ACK_TIMEOUT_EN.
module descriptor_dequeue
    import tsn_desc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DESC_W-1:0]     iv_fifo_rdata,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    output logic [TSNTAG_W-1:0]   ov_tsntag_ts,
    output logic [BUFID_W-1:0]    ov_bufid_ts,
    output logic [PKT_TYPE_W-1:0] ov_pkt_type_ts,
    output logic                  o_descriptor_wr_ts,
    input  logic                  i_descriptor_ack_ts,
    output logic [TSNTAG_W-1:0]   ov_tsntag_be,
    output logic [BUFID_W-1:0]    ov_bufid_be,
    output logic [PKT_TYPE_W-1:0] ov_pkt_type_be,
    output logic                  o_descriptor_wr_be,
    input  logic                  i_descriptor_ack_be,
    output logic [15:0]           ov_drop_cnt
);

    state_e state_q, state_d;
    logic   rd_q, rd_d;
    logic   wr_ts_q, wr_ts_d;
    logic   wr_be_q, wr_be_d;
    desc_t  ts_q, ts_d;
    desc_t  be_q, be_d;
    desc_t  cap;
    logic   ack_sel;
    logic   expire;

    assign cap.pkt_type = iv_fifo_rdata[PKT_TYPE_MSB:PKT_TYPE_LSB];
    assign cap.tsntag   = iv_fifo_rdata[TSNTAG_MSB:TSNTAG_LSB];
    assign cap.bufid    = iv_fifo_rdata[BUFID_MSB:BUFID_LSB];

    assign ack_sel = wr_ts_q ? i_descriptor_ack_ts : i_descriptor_ack_be;

`ifdef DESC_ACK_TIMEOUT_EN
    desc_ack_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (state_q == CAPTURE_S),
        .i_wait     (state_q == WAIT_ACK_S),
        .i_ack      (ack_sel),
        .o_expire   (expire),
        .ov_drop_cnt(ov_drop_cnt)
    );
`else
    assign expire      = 1'b0;
    assign ov_drop_cnt = '0;
`endif

    // Dequeue FSM: pop, wait a cycle for read data, capture, await ack.
    always_comb begin
        state_d = state_q;
        rd_d    = 1'b0;
        wr_ts_d = wr_ts_q;
        wr_be_d = wr_be_q;
        ts_d    = ts_q;
        be_d    = be_q;
        case (state_q)
            IDLE_S: begin
                if (!i_fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = READ_S;
                end
            end
            READ_S: begin
                state_d = CAPTURE_S;
            end
            CAPTURE_S: begin
                if (is_ts(cap.pkt_type)) begin
                    ts_d    = cap;
                    wr_ts_d = 1'b1;
                end else begin
                    be_d    = cap;
                    wr_be_d = 1'b1;
                end
                state_d = WAIT_ACK_S;
            end
            WAIT_ACK_S: begin
                if (ack_sel || expire) begin
                    wr_ts_d = 1'b0;
                    wr_be_d = 1'b0;
                    ts_d    = '0;
                    be_d    = '0;
                    state_d = IDLE_S;
                end
            end
            default: begin
                wr_ts_d = 1'b0;
                wr_be_d = 1'b0;
                ts_d    = '0;
                be_d    = '0;
                state_d = IDLE_S;
            end
        endcase
    end

    // State and output registers; reset drops any outstanding descriptor.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE_S;
            rd_q    <= 1'b0;
            wr_ts_q <= 1'b0;
            wr_be_q <= 1'b0;
            ts_q    <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_ts_q <= wr_ts_d;
            wr_be_q <= wr_be_d;
            ts_q    <= ts_d;
            be_q    <= be_d;
        end
    end

    assign o_fifo_rd          = rd_q;
    assign o_descriptor_wr_ts = wr_ts_q;
    assign o_descriptor_wr_be = wr_be_q;
    assign ov_pkt_type_ts     = ts_q.pkt_type;
    assign ov_tsntag_ts       = ts_q.tsntag;
    assign ov_bufid_ts        = ts_q.bufid;
    assign ov_pkt_type_be     = be_q.pkt_type;
    assign ov_tsntag_be       = be_q.tsntag;
    assign ov_bufid_be        = be_q.bufid;

endmodule

// File: tb/tb_descriptor_dequeue.sv
// Self-checking bench for descriptor_dequeue: FIFO model, directed
// vector table, back-to-back, reset, empty and optional timeout cases.
module tb_descriptor_dequeue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [59:0] rdata = '0;
    logic        empty;
    logic        rd;
    logic [47:0] tag_ts, tag_be;
    logic [8:0]  buf_ts, buf_be;
    logic [2:0]  typ_ts, typ_be;
    logic        wr_ts, wr_be;
    logic        ack_ts = 1'b0;
    logic        ack_be = 1'b0;
    logic [15:0] drop;

    int passed = 0;
    int total  = 0;

    logic [59:0] mem [0:63];
    int wp = 0;
    int rp = 0;

    always #5 clk = ~clk;

    assign empty = (wp == rp);

    always @(posedge clk) begin
        if (rd && (rp != wp)) begin
            rdata <= mem[rp];
            rp    <= rp + 1;
        end
    end

    descriptor_dequeue #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .iv_fifo_rdata      (rdata),
        .i_fifo_empty       (empty),
        .o_fifo_rd          (rd),
        .ov_tsntag_ts       (tag_ts),
        .ov_bufid_ts        (buf_ts),
        .ov_pkt_type_ts     (typ_ts),
        .o_descriptor_wr_ts (wr_ts),
        .i_descriptor_ack_ts(ack_ts),
        .ov_tsntag_be       (tag_be),
        .ov_bufid_be        (buf_be),
        .ov_pkt_type_be     (typ_be),
        .o_descriptor_wr_be (wr_be),
        .i_descriptor_ack_be(ack_be),
        .ov_drop_cnt        (drop)
    );

    typedef struct {
        logic [59:0] d;
        int          delay;
        logic        exp_ts;
        logic        wrong_ack;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic push(input logic [59:0] d);
        mem[wp] = d;
        wp = wp + 1;
    endtask

    function automatic logic [59:0] f_ts();
        return {typ_ts, tag_ts, buf_ts};
    endfunction

    function automatic logic [59:0] f_be();
        return {typ_be, tag_be, buf_be};
    endfunction

    task automatic wait_rd(input string nm, output logic got);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd) begin
                got = 1'b1;
                break;
            end
        end
        check(nm, 64'(got), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic got;
        push(v.d);
        wait_rd("rd_seen", got);
        if (!got) return;
        @(negedge clk);
        check("rd_one_cycle", {61'd0, rd, wr_ts, wr_be}, 64'd0);
        @(negedge clk);
        check("wr_route", {62'd0, wr_ts, wr_be},
              v.exp_ts ? 64'd2 : 64'd1);
        check("fields_sel", 64'(v.exp_ts ? f_ts() : f_be()), 64'(v.d));
        check("fields_other", 64'(v.exp_ts ? f_be() : f_ts()), 64'd0);
        for (int j = 0; j < v.delay; j++) begin
            if (v.wrong_ack && j == 0) begin
                if (v.exp_ts) ack_be = 1'b1;
                else ack_ts = 1'b1;
            end
            @(negedge clk);
            ack_ts = 1'b0;
            ack_be = 1'b0;
        end
        check("wr_held", {62'd0, wr_ts, wr_be}, v.exp_ts ? 64'd2 : 64'd1);
        check("fields_held", 64'(v.exp_ts ? f_ts() : f_be()), 64'(v.d));
        if (v.exp_ts) ack_ts = 1'b1;
        else ack_be = 1'b1;
        @(negedge clk);
        ack_ts = 1'b0;
        ack_be = 1'b0;
        check("wr_clear", {62'd0, wr_ts, wr_be}, 64'd0);
        check("fields_clear", 64'(f_ts() | f_be()), 64'd0);
    endtask

    initial begin
        logic        got;
        int          hi;
        int          nrx;
        int          bad;
        logic [59:0] rx [4];
        logic [59:0] exp4 [4];

        vecs[0] = '{{3'd1, 48'h0123_4567_89AB, 9'h005}, 3, 1'b1, 1'b0};
        vecs[1] = '{{3'd5, 48'hDEAD_BEEF_0001, 9'h1FF}, 2, 1'b0, 1'b1};
        vecs[2] = '{{3'd0, 48'hFFFF_FFFF_FFFF, 9'h000}, 1, 1'b1, 1'b1};
        vecs[3] = '{{3'd2, 48'h0000_0000_0001, 9'h100}, 0, 1'b1, 1'b0};
        vecs[4] = '{{3'd3, 48'hA5A5_5A5A_A5A5, 9'h0AA}, 4, 1'b0, 1'b1};
        vecs[5] = '{{3'd7, 48'hFFFF_FFFF_FFFF, 9'h155}, 1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_flags", {61'd0, rd, wr_ts, wr_be}, 64'd0);
        check("reset_drop", 64'(drop), 64'd0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd || wr_ts || wr_be || (f_ts() | f_be()) != 0 || drop != 0)
                bad++;
        end
        check("empty_idle", 64'(bad), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        exp4[0] = {3'd2, 48'h1111_1111_1111, 9'h011};
        exp4[1] = {3'd6, 48'h2222_2222_2222, 9'h022};
        exp4[2] = {3'd4, 48'h3333_3333_3333, 9'h033};
        exp4[3] = {3'd0, 48'h4444_4444_4444, 9'h044};
        foreach (exp4[i]) push(exp4[i]);
        nrx = 0;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ack_ts = 1'b0;
            ack_be = 1'b0;
            if (wr_ts && wr_be) bad++;
            if (wr_ts && nrx < 4) begin
                rx[nrx] = f_ts();
                nrx++;
                ack_ts = 1'b1;
            end else if (wr_be && nrx < 4) begin
                rx[nrx] = f_be();
                nrx++;
                ack_be = 1'b1;
            end
        end
        @(negedge clk);
        ack_ts = 1'b0;
        ack_be = 1'b0;
        check("b2b_count", 64'(nrx), 64'd4);
        check("b2b_exclusive", 64'(bad), 64'd0);
        for (int i = 0; i < 4; i++)
            if (i < nrx) check("b2b_order", 64'(rx[i]), 64'(exp4[i]));
        check("b2b_done", {61'd0, rd, wr_ts, wr_be}, 64'd0);

        push({3'd1, 48'hCAFE_0000_BEEF, 9'h077});
        wait_rd("rst_rd_seen", got);
        repeat (2) @(negedge clk);
        check("pre_rst_wr", 64'(wr_ts), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_flags", {61'd0, rd, wr_ts, wr_be}, 64'd0);
        check("async_rst_fields", 64'(f_ts() | f_be()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_drop", 64'(drop), 64'd0);
        run_vec('{{3'd6, 48'h0BAD_F00D_0000, 9'h0F0}, 1, 1'b0, 1'b1});

`ifdef DESC_ACK_TIMEOUT_EN
        push({3'd1, 48'h7777_0000_7777, 9'h007});
        push({3'd4, 48'h8888_0000_8888, 9'h008});
        hi = 0;
        for (int k = 0; k < 40 && hi == 0; k++) begin
            @(negedge clk);
            if (wr_ts) hi = 1;
        end
        for (int k = 0; k < 20 && wr_ts; k++) begin
            @(negedge clk);
            if (wr_ts) hi++;
        end
        check("to_wait_cycles", 64'(hi), 64'd8);
        check("to_drop_cnt", 64'(drop), 64'd1);
        check("to_fields_clear", 64'(f_ts()), 64'd0);
        hi = 0;
        for (int k = 0; k < 20 && hi == 0; k++) begin
            @(negedge clk);
            if (wr_be) hi = 1;
        end
        check("to_next_popped", 64'(f_be()), 64'({3'd4, 48'h8888_0000_8888, 9'h008}));
        for (int k = 0; k < 20 && wr_be; k++) begin
            if (hi == 8) ack_be = 1'b1;
            @(negedge clk);
            ack_be = 1'b0;
            if (wr_be) hi++;
        end
        check("ack_at_expiry_cycles", 64'(hi), 64'd8);
        check("ack_at_expiry_drop", 64'(drop), 64'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
